// File: rtl/lift_controller.sv
// Two-floor lift sequencer: latches floor calls, times cab travel and door intervals
// from a slow tick, and presents the current action code as a Moore output.
module lift_controller #(
  parameter int TRAVEL_TICKS = 8,
  parameter int DOOR_TICKS   = 4,
  parameter int CW           = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       req1,
  input  logic       req2,
  input  logic       door_hold,
  output logic [2:0] action,
  output logic       floor,
  output logic       pend1,
  output logic       pend2,
  output logic       busy
);

  // state | meaning: DN moving down, A1/A2 parked doors closed, UP moving up,
  // R1/R2 doors open, INIT blank after reset, BAD unused code (recovers to INIT)
  typedef enum logic [2:0] {
    S_DN   = 3'b000,
    S_A1   = 3'b001,
    S_UP   = 3'b010,
    S_A2   = 3'b011,
    S_R1   = 3'b100,
    S_R2   = 3'b101,
    S_INIT = 3'b110,
    S_BAD  = 3'b111
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          pend1_nxt, pend2_nxt;
  logic          travel_done, door_done, hold_door, in_door;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_INIT;
      cnt   <= '0;
      pend1 <= 1'b0;
      pend2 <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      pend1 <= pend1_nxt;
      pend2 <= pend2_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pend1_nxt   = pend1;
    pend2_nxt   = pend2;
    travel_done = tick && (cnt == CW'(TRAVEL_TICKS - 1));
    door_done   = tick && (cnt == CW'(DOOR_TICKS - 1));
    in_door     = (state == S_R1) || (state == S_R2);
    // A call for the floor whose doors are open re-opens them like door_hold
    hold_door   = door_hold || (state == S_R1 && req1) || (state == S_R2 && req2);

    case (state)
      S_INIT: state_nxt = S_A1;
      S_A1: begin
        if (pend1 || req1)      state_nxt = S_R1;
        else if (pend2 || req2) state_nxt = S_UP;
      end
      S_A2: begin
        if (pend2 || req2)      state_nxt = S_R2;
        else if (pend1 || req1) state_nxt = S_DN;
      end
      S_UP: if (travel_done) state_nxt = S_R2;
      S_DN: if (travel_done) state_nxt = S_R1;
      S_R1: if (!hold_door && door_done) state_nxt = S_A1;
      S_R2: if (!hold_door && door_done) state_nxt = S_A2;
      default: state_nxt = S_INIT;
    endcase

    if (state_nxt != state)        cnt_nxt = '0;
    else if (in_door && hold_door) cnt_nxt = '0;
    else if (tick)                 cnt_nxt = cnt + 1'b1;

    if (req1 && state != S_DN && state != S_R1) pend1_nxt = 1'b1;
    if (req2 && state != S_UP && state != S_R2) pend2_nxt = 1'b1;
    if (state_nxt == S_R1 && state != S_R1)     pend1_nxt = 1'b0;
    if (state_nxt == S_R2 && state != S_R2)     pend2_nxt = 1'b0;
  end

  assign action = state;
  assign floor  = (state == S_A2) || (state == S_R2) || (state == S_DN);
  assign busy   = (state == S_UP) || (state == S_DN) || (state == S_R1) || (state == S_R2);

endmodule
